// File: rtl/weight_buffer_db.sv
// weight_buffer_db: double-buffered convolution weight store.
// Words stream serially into a shadow bank; a swap copies a complete shadow
// set into the active bank in one cycle so the convolver sees a stable kernel.
// Optional feature macro: WEIGHT_BUFFER_PARALLEL_EN adds a one-cycle parallel
// shadow load through the write / weight_write ports.
module weight_buffer_db #(
   parameter  int DATA_WIDTH = 16,
   parameter  int N          = 25,
   localparam int CNT_W      = $clog2(N + 1)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [DATA_WIDTH-1:0]   load_data,
   input  logic                    swap,
   input  logic                    flush,
`ifdef WEIGHT_BUFFER_PARALLEL_EN
   input  logic                    write,
   input  logic [N*DATA_WIDTH-1:0] weight_write,
`endif
   output logic                    shadow_full,
   output logic [CNT_W-1:0]        load_count,
   output logic                    active_valid,
   output logic [N*DATA_WIDTH-1:0] weight_read
);

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_FULL = 1'b1
   } state_t;

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    count_reg, count_next;
   logic                active_valid_reg;
   logic                swap_fire;
   logic                par_fire;
   logic                load_fire;
   logic                write_en;
   logic [N*DATA_WIDTH-1:0] write_bus;

`ifdef WEIGHT_BUFFER_PARALLEL_EN
   assign write_en  = write;
   assign write_bus = weight_write;
`else
   assign write_en  = 1'b0;
   assign write_bus = '0;
`endif

   // State and fill-count registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= ST_LOAD;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
      end
   end

   // Next-state logic: flush beats swap/parallel write, which beat serial load
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      swap_fire  = 1'b0;
      par_fire   = 1'b0;
      load_fire  = 1'b0;
      if (flush) begin
         state_next = ST_LOAD;
         count_next = '0;
      end else begin
         if (state_reg == ST_FULL && swap) begin
            swap_fire  = 1'b1;
            state_next = ST_LOAD;
            count_next = '0;
         end
         // A parallel write lands after any same-cycle swap has taken the old set
         if (write_en) begin
            par_fire   = 1'b1;
            state_next = ST_FULL;
            count_next = CNT_W'(N);
         end else if (!swap_fire && load_valid && load_ready) begin
            load_fire  = 1'b1;
            count_next = count_reg + CNT_W'(1);
            if (count_reg == CNT_W'(N - 1)) begin
               state_next = ST_FULL;
            end
         end
      end
   end

   // Outputs decoded from state only (ready never looks at load_valid)
   always_comb begin
      load_ready  = (state_reg == ST_LOAD) && !reset && !write_en;
      shadow_full = (state_reg == ST_FULL);
   end

   // Active set becomes valid on the first swap and stays valid until reset
   always_ff @(posedge clock) begin
      if (reset) begin
         active_valid_reg <= 1'b0;
      end else if (swap_fire) begin
         active_valid_reg <= 1'b1;
      end
   end

   assign load_count   = count_reg;
   assign active_valid = active_valid_reg;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_slot
         logic [DATA_WIDTH-1:0] shadow_reg;
         logic [DATA_WIDTH-1:0] active_reg;

         // Shadow slot: parallel load or the serial word addressed by the count
         always_ff @(posedge clock) begin
            if (reset) begin
               shadow_reg <= '0;
            end else if (par_fire) begin
               shadow_reg <= write_bus[gi*DATA_WIDTH +: DATA_WIDTH];
            end else if (load_fire && count_reg == CNT_W'(gi)) begin
               shadow_reg <= load_data;
            end
         end

         // Active slot: captures the shadow word on a swap
         always_ff @(posedge clock) begin
            if (reset) begin
               active_reg <= '0;
            end else if (swap_fire) begin
               active_reg <= shadow_reg;
            end
         end

         assign weight_read[gi*DATA_WIDTH +: DATA_WIDTH] = active_reg;
      end
   endgenerate

endmodule

// File: tb/tb_weight_buffer_db.sv
// Testbench for weight_buffer_db: a hand-written vector table for short
// control sequences, then kernel streams checked against a behavioural model
// with a queue of expected kernels for each swap.
module tb_weight_buffer_db;

   localparam int DW    = 16;
   localparam int N     = 25;
   localparam int CNT_W = $clog2(N + 1);
   localparam int NW    = N * DW;

   logic              clock = 1'b0;
   logic              reset;
   logic              load_valid;
   logic              load_ready;
   logic [DW-1:0]     load_data;
   logic              swap;
   logic              flush;
   logic              shadow_full;
   logic [CNT_W-1:0]  load_count;
   logic              active_valid;
   logic [NW-1:0]     weight_read;
   logic              wr;
   logic [NW-1:0]     wdata;

   weight_buffer_db #(.DATA_WIDTH(DW), .N(N)) dut (
      .clock        (clock),
      .reset        (reset),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .load_data    (load_data),
      .swap         (swap),
      .flush        (flush),
`ifdef WEIGHT_BUFFER_PARALLEL_EN
      .write        (wr),
      .weight_write (wdata),
`endif
      .shadow_full  (shadow_full),
      .load_count   (load_count),
      .active_valid (active_valid),
      .weight_read  (weight_read)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model
   bit            m_full;
   int            m_count;
   bit            m_valid;
   logic [DW-1:0] m_shadow [N];
   logic [DW-1:0] m_active [N];
   logic [NW-1:0] exp_q [$];
   bit            ready_seen;

   typedef struct {
      bit            r;
      bit            lv;
      logic [DW-1:0] d;
      bit            sw;
      bit            fl;
      bit            e_ready;
      int            e_count;
      bit            e_full;
      bit            e_valid;
   } vec_t;

   vec_t tbl [9];

   function automatic logic [NW-1:0] flat(input logic [DW-1:0] a [N]);
      logic [NW-1:0] v;
      for (int i = 0; i < N; i++) v[i*DW +: DW] = a[i];
      return v;
   endfunction

   function automatic logic [DW-1:0] word_of(input logic [NW-1:0] v, input int i);
      return v[i*DW +: DW];
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkw(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock cycle: drive, check ready, advance model, clock, check outputs
   task automatic apply(input bit r, input bit lv, input logic [DW-1:0] d,
                        input bit sw, input bit fl);
      bit ready_exp;
      bit swapf;
      reset      = r;
      load_valid = lv;
      load_data  = d;
      swap       = sw;
      flush      = fl;
      #1;
      ready_exp  = !m_full && !r && !wr;
      ready_seen = load_ready;
      check("load_ready", int'(load_ready), int'(ready_exp));
      swapf = 1'b0;
      if (r) begin
         m_full  = 1'b0;
         m_count = 0;
         m_valid = 1'b0;
         for (int i = 0; i < N; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
         end
      end else if (fl) begin
         m_full  = 1'b0;
         m_count = 0;
      end else begin
         if (m_full && sw) begin
            swapf = 1'b1;
            exp_q.push_back(flat(m_shadow));
            m_active = m_shadow;
            m_valid  = 1'b1;
            m_count  = 0;
            m_full   = 1'b0;
         end
         if (wr) begin
            for (int i = 0; i < N; i++) m_shadow[i] = wdata[i*DW +: DW];
            m_count = N;
            m_full  = 1'b1;
         end else if (!swapf && lv && ready_exp) begin
            m_shadow[m_count] = d;
            m_count++;
            if (m_count == N) m_full = 1'b1;
         end
      end
      @(posedge clock);
      #1;
      check("load_count", int'(load_count), m_count);
      check("shadow_full", int'(shadow_full), int'(m_full));
      check("active_valid", int'(active_valid), int'(m_valid));
      if (swapf) begin
         checkw("weight_read_swap", weight_read, exp_q.pop_front());
      end else begin
         checkw("weight_read_hold", weight_read, flat(m_active));
      end
      $display("cycle r=%0b lv=%0b d=%h sw=%0b fl=%0b -> ready=%0b cnt=%0d full=%0b valid=%0b w0=%h",
               r, lv, d, sw, fl, ready_seen, load_count, shadow_full, active_valid,
               weight_read[DW-1:0]);
   endtask

   task automatic stream(input logic [DW-1:0] base, input int n);
      for (int i = 0; i < n; i++) apply(1'b0, 1'b1, base + DW'(i), 1'b0, 1'b0);
   endtask

   initial begin
      reset      = 1'b1;
      load_valid = 1'b0;
      load_data  = '0;
      swap       = 1'b0;
      flush      = 1'b0;
      wr         = 1'b0;
      wdata      = '0;
      m_full     = 1'b0;
      m_count    = 0;
      m_valid    = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_shadow[i] = '0;
         m_active[i] = '0;
      end

      // r lv d sw fl | ready count full valid
      tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 16'hCCCC, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 16'hDDDD, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 1'b1, 16'hEEEE, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
      tbl[8] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0};

      for (int i = 0; i < 9; i++) begin
         apply(tbl[i].r, tbl[i].lv, tbl[i].d, tbl[i].sw, tbl[i].fl);
         check("tbl_ready", int'(ready_seen), int'(tbl[i].e_ready));
         check("tbl_count", int'(load_count), tbl[i].e_count);
         check("tbl_full", int'(shadow_full), int'(tbl[i].e_full));
         check("tbl_valid", int'(active_valid), int'(tbl[i].e_valid));
      end
      checkw("tbl_weight_read", weight_read, '0);

      // Full kernel 0x0001..0x0019 then swap
      apply(1'b1, 1'b0, '0, 1'b0, 1'b0);
      stream(16'h0001, N);
      check("full_after_25", int'(shadow_full), 1);
      check("count_after_25", int'(load_count), N);
      apply(1'b0, 1'b0, '0, 1'b1, 1'b0);
      check("swap1_w0", int'(word_of(weight_read, 0)), 16'h0001);
      check("swap1_wtop", int'(word_of(weight_read, N - 1)), 16'h0019);
      check("swap1_valid", int'(active_valid), 1);
      check("swap1_count", int'(load_count), 0);

      // Partial load, flush, fresh kernel, swap
      stream(16'h0100, 10);
      apply(1'b0, 1'b0, '0, 1'b0, 1'b1);
      check("flush_count", int'(load_count), 0);
      check("flush_keeps_active", int'(word_of(weight_read, 0)), 16'h0001);
      stream(16'h0200, N);
      apply(1'b0, 1'b0, '0, 1'b1, 1'b0);
      check("flush_new_w0", int'(word_of(weight_read, 0)), 16'h0200);
      check("flush_new_w9", int'(word_of(weight_read, 9)), 16'h0209);

      // Next set, then hold load_valid high in FULL
      stream(16'h0300, N);
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0);
         check("full_ready_low", int'(ready_seen), 0);
         check("full_count_hold", int'(load_count), N);
         check("full_active_hold", int'(word_of(weight_read, 0)), 16'h0200);
      end
      apply(1'b0, 1'b0, '0, 1'b1, 1'b0);
      check("hold_swap_w0", int'(word_of(weight_read, 0)), 16'h0300);
      check("hold_swap_wtop", int'(word_of(weight_read, N - 1)), 16'h0318);

      // Swap together with the final word is ignored
      stream(16'h0400, N - 1);
      apply(1'b0, 1'b1, 16'h0418, 1'b1, 1'b0);
      check("late_swap_full", int'(shadow_full), 1);
      check("late_swap_no_xfer", int'(word_of(weight_read, 0)), 16'h0300);
      apply(1'b0, 1'b0, '0, 1'b1, 1'b0);
      check("late_swap_w0", int'(word_of(weight_read, 0)), 16'h0400);
      check("late_swap_wtop", int'(word_of(weight_read, N - 1)), 16'h0418);

      // Reset mid-stream with active loaded
      stream(16'h0500, 12);
      check("mid_count", int'(load_count), 12);
      apply(1'b1, 1'b1, 16'h0555, 1'b0, 1'b0);
      checkw("rst_weight_read", weight_read, '0);
      check("rst_valid", int'(active_valid), 0);
      check("rst_full", int'(shadow_full), 0);
      check("rst_count", int'(load_count), 0);
      apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
      check("rst_ready_after", int'(ready_seen), 1);

`ifdef WEIGHT_BUFFER_PARALLEL_EN
      begin
         logic [NW-1:0] p1;
         logic [NW-1:0] p2;
         for (int i = 0; i < N; i++) begin
            p1[i*DW +: DW] = 16'hA000 + DW'(i * 3);
            p2[i*DW +: DW] = 16'h5000 + DW'(i * 7);
         end
         wr    = 1'b1;
         wdata = p1;
         apply(1'b0, 1'b1, 16'h0BAD, 1'b0, 1'b0);
         check("par_ready_low", int'(ready_seen), 0);
         check("par_full", int'(shadow_full), 1);
         check("par_count", int'(load_count), N);
         wr = 1'b0;
         apply(1'b0, 1'b0, '0, 1'b1, 1'b0);
         checkw("par_swap", weight_read, p1);
         wr    = 1'b1;
         wdata = p1;
         apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
         wdata = p2;
         apply(1'b0, 1'b0, '0, 1'b1, 1'b0);
         checkw("par_write_swap_old", weight_read, p1);
         check("par_write_swap_full", int'(shadow_full), 1);
         wr = 1'b0;
         apply(1'b0, 1'b0, '0, 1'b1, 1'b0);
         checkw("par_write_swap_new", weight_read, p2);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
